// File: rtl/display_mux_scan.sv
// Priority-selected, held display value driving a time-multiplexed active-low
// 7-segment hex display with optional leading-zero blanking.
module display_mux_scan #(
   parameter int DATA_W   = 16,
   parameter int NUM_SRC  = 2,
   parameter int SCAN_DIV = 100000,
   parameter int BLANK_LZ = 1
) (
   input  logic                                        clk,
   input  logic                                        rst,
   input  logic [NUM_SRC-1:0]                          src_valid,
   input  logic [NUM_SRC*DATA_W-1:0]                   src_data,
   input  logic                                        freeze,
   output logic [DATA_W-1:0]                           disp_value,
   output logic [(NUM_SRC > 1 ? $clog2(NUM_SRC) : 1)-1:0] disp_src,
   output logic                                        updated,
   output logic [6:0]                                  seg,
   output logic [DATA_W/4-1:0]                         an
);

   localparam int DIGITS = DATA_W / 4;
   localparam int SRC_W  = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
   localparam int CNT_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int DIG_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   logic [DATA_W-1:0] r_value;
   logic [SRC_W-1:0]  r_src;
   logic              r_updated;
   logic [CNT_W-1:0]  r_div_cnt;
   logic [DIG_W-1:0]  r_dig_idx;
   logic [6:0]        r_seg;
   logic [DIGITS-1:0] r_an;

   logic              w_hit;
   logic [SRC_W-1:0]  w_sel;
   logic [DATA_W-1:0] w_sel_data;
   logic [DATA_W-1:0] w_upper;
   logic [3:0]        w_nib;
   logic              w_blank;
   logic              w_div_wrap;

   function automatic logic [6:0] f_hex7(input logic [3:0] n);
      logic [6:0] s;
      case (n)
         4'h0: s = 7'h40;
         4'h1: s = 7'h79;
         4'h2: s = 7'h24;
         4'h3: s = 7'h30;
         4'h4: s = 7'h19;
         4'h5: s = 7'h12;
         4'h6: s = 7'h02;
         4'h7: s = 7'h78;
         4'h8: s = 7'h00;
         4'h9: s = 7'h10;
         4'hA: s = 7'h08;
         4'hB: s = 7'h03;
         4'hC: s = 7'h46;
         4'hD: s = 7'h21;
         4'hE: s = 7'h06;
         default: s = 7'h0E;
      endcase
      return s;
   endfunction

   // Lowest valid index wins; higher-index requests in the same cycle are dropped.
   always_comb begin
      w_hit      = 1'b0;
      w_sel      = '0;
      w_sel_data = '0;
      for (int unsigned i = 0; i < NUM_SRC; i++) begin
         if (src_valid[i] && !w_hit) begin
            w_hit      = 1'b1;
            w_sel      = SRC_W'(i);
            w_sel_data = src_data[i*DATA_W +: DATA_W];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_value   <= '0;
         r_src     <= '0;
         r_updated <= 1'b0;
      end else if (!freeze && w_hit) begin
         r_value   <= w_sel_data;
         r_src     <= w_sel;
         r_updated <= 1'b1;
      end else begin
         r_updated <= 1'b0;
      end
   end

   assign w_div_wrap = (r_div_cnt == CNT_W'(SCAN_DIV - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_div_cnt <= '0;
         r_dig_idx <= '0;
      end else if (w_div_wrap) begin
         r_div_cnt <= '0;
         r_dig_idx <= (r_dig_idx == DIG_W'(DIGITS - 1)) ? '0 : r_dig_idx + 1'b1;
      end else begin
         r_div_cnt <= r_div_cnt + 1'b1;
      end
   end

   // Shifting the current digit down to bit 0 gives both its nibble and whether
   // every nibble from here upward is zero.
   always_comb begin
      w_upper = r_value >> {r_dig_idx, 2'b00};
      w_nib   = w_upper[3:0];
      w_blank = (BLANK_LZ != 0) && (r_dig_idx != '0) && (w_upper == '0);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_seg <= '1;
         r_an  <= '1;
      end else begin
         r_an  <= ~(DIGITS'(1) << r_dig_idx);
         r_seg <= w_blank ? 7'h7F : f_hex7(w_nib);
      end
   end

   assign disp_value = r_value;
   assign disp_src   = r_src;
   assign updated    = r_updated;
   assign seg        = r_seg;
   assign an         = r_an;

endmodule

// File: tb/tb_display_mux_scan.sv
// Directed bench for display_mux_scan: selection table plus hand-computed scan,
// blanking and reset sequences on two parameterisations sharing the same inputs.
module tb_display_mux_scan;

   logic        clk;
   logic        rst;
   logic [1:0]  src_valid;
   logic [15:0] d0, d1;
   logic        freeze;

   logic [15:0] v1, v2;
   logic        s1, s2;
   logic        u1, u2;
   logic [6:0]  seg1, seg2;
   logic [3:0]  an1, an2;

   int n_checks = 0;
   int n_errors = 0;

   display_mux_scan #(.DATA_W(16), .NUM_SRC(2), .SCAN_DIV(2), .BLANK_LZ(1)) dut (
      .clk(clk), .rst(rst), .src_valid(src_valid), .src_data({d1, d0}), .freeze(freeze),
      .disp_value(v1), .disp_src(s1), .updated(u1), .seg(seg1), .an(an1)
   );

   display_mux_scan #(.DATA_W(16), .NUM_SRC(2), .SCAN_DIV(1), .BLANK_LZ(0)) dut_nb (
      .clk(clk), .rst(rst), .src_valid(src_valid), .src_data({d1, d0}), .freeze(freeze),
      .disp_value(v2), .disp_src(s2), .updated(u2), .seg(seg2), .an(an2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic chk_dark(input string tag);
      chk({tag, " seg1"}, 32'(seg1), 32'h7F);
      chk({tag, " an1"},  32'(an1),  32'hF);
      chk({tag, " seg2"}, 32'(seg2), 32'h7F);
      chk({tag, " an2"},  32'(an2),  32'hF);
      chk({tag, " value"}, 32'(v1), 32'h0);
      chk({tag, " src"},   32'(s1), 32'h0);
      chk({tag, " upd"},   32'(u1), 32'h0);
   endtask

   typedef struct {
      logic [1:0]  valid;
      logic [15:0] d0;
      logic [15:0] d1;
      logic        frz;
      logic [15:0] ev;
      logic        es;
      logic        eu;
   } vec_t;

   vec_t vecs[12];

   // Scan expectations for 18 edges after reset release (SCAN_DIV=2/blank, SCAN_DIV=1/no blank)
   logic [6:0] e1_seg[18] = '{7'h40, 7'h12, 7'h08, 7'h08, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h12,
                              7'h12, 7'h08, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40, 7'h40};
   logic [3:0] e1_an[18]  = '{4'hE, 4'hE, 4'hD, 4'hD, 4'hB, 4'hB, 4'h7, 4'h7, 4'hE,
                              4'hE, 4'hD, 4'hD, 4'hB, 4'hB, 4'h7, 4'h7, 4'hE, 4'hE};
   logic [6:0] e2_seg[18] = '{7'h40, 7'h08, 7'h40, 7'h40, 7'h12, 7'h08, 7'h40, 7'h40, 7'h12,
                              7'h08, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};
   logic [3:0] e2_an[18]  = '{4'hE, 4'hD, 4'hB, 4'h7, 4'hE, 4'hD, 4'hB, 4'h7, 4'hE,
                              4'hD, 4'hB, 4'h7, 4'hE, 4'hD, 4'hB, 4'h7, 4'hE, 4'hD};

   initial begin
      //            valid  d0       d1       frz   value    src   upd
      vecs[0]  = '{2'b11, 16'h1234, 16'hBEEF, 1'b0, 16'h1234, 1'b0, 1'b1};
      vecs[1]  = '{2'b00, 16'h1234, 16'hBEEF, 1'b0, 16'h1234, 1'b0, 1'b0};
      vecs[2]  = '{2'b10, 16'h0000, 16'h00A5, 1'b0, 16'h00A5, 1'b1, 1'b1};
      vecs[3]  = '{2'b01, 16'hFFFF, 16'h0000, 1'b1, 16'h00A5, 1'b1, 1'b0};
      vecs[4]  = '{2'b11, 16'hFFFF, 16'h1111, 1'b1, 16'h00A5, 1'b1, 1'b0};
      vecs[5]  = '{2'b10, 16'hFFFF, 16'h0001, 1'b0, 16'h0001, 1'b1, 1'b1};
      vecs[6]  = '{2'b10, 16'hFFFF, 16'h0002, 1'b0, 16'h0002, 1'b1, 1'b1};
      vecs[7]  = '{2'b10, 16'hFFFF, 16'h0003, 1'b0, 16'h0003, 1'b1, 1'b1};
      vecs[8]  = '{2'b00, 16'hFFFF, 16'h0009, 1'b0, 16'h0003, 1'b1, 1'b0};
      vecs[9]  = '{2'b01, 16'h0000, 16'h0009, 1'b0, 16'h0000, 1'b0, 1'b1};
      vecs[10] = '{2'b10, 16'h7777, 16'h00A5, 1'b0, 16'h00A5, 1'b1, 1'b1};
      vecs[11] = '{2'b10, 16'h7777, 16'hBEEF, 1'b0, 16'hBEEF, 1'b1, 1'b1};

      rst = 1'b1; src_valid = '0; d0 = '0; d1 = '0; freeze = 1'b0;
      #12;
      chk_dark("reset");
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 12; i++) begin
         src_valid = vecs[i].valid; d0 = vecs[i].d0; d1 = vecs[i].d1; freeze = vecs[i].frz;
         @(posedge clk); #1;
         chk($sformatf("vec%0d value", i), 32'(v1), 32'(vecs[i].ev));
         chk($sformatf("vec%0d src", i),   32'(s1), 32'(vecs[i].es));
         chk($sformatf("vec%0d upd", i),   32'(u1), 32'(vecs[i].eu));
         chk($sformatf("vec%0d value2", i), 32'(v2), 32'(vecs[i].ev));
      end

      src_valid = '0; freeze = 1'b0;
      repeat (5) @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      chk_dark("async reset");

      // Load request held through reset must not land until reset is released.
      src_valid = 2'b10; d1 = 16'h00A5;
      @(posedge clk); #1;
      chk_dark("reset held");
      @(negedge clk);
      rst = 1'b0;

      for (int e = 0; e < 18; e++) begin
         @(posedge clk); #1;
         chk($sformatf("scan e%0d seg1", e + 1), 32'(seg1), 32'(e1_seg[e]));
         chk($sformatf("scan e%0d an1", e + 1),  32'(an1),  32'(e1_an[e]));
         chk($sformatf("scan e%0d seg2", e + 1), 32'(seg2), 32'(e2_seg[e]));
         chk($sformatf("scan e%0d an2", e + 1),  32'(an2),  32'(e2_an[e]));
         if (e == 0) begin
            chk("post-reset load value", 32'(v1), 32'h00A5);
            chk("post-reset load src",   32'(s1), 32'h1);
            chk("post-reset load upd",   32'(u1), 32'h1);
            src_valid = '0;
         end
         if (e == 1) chk("post-reset upd drop", 32'(u1), 32'h0);
         if (e == 9) begin
            src_valid = 2'b01; d0 = 16'h0000;
         end
         if (e == 10) begin
            chk("zero load value", 32'(v1), 32'h0);
            chk("zero load upd",   32'(u1), 32'h1);
            src_valid = '0;
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not complete, expected finish before 100000");
      $fatal(1);
   end

endmodule
